// File: rtl/mult_issue_scheduler.sv
// Arbitrates two requesters onto the shared fixed-latency multiplier and routes results by tag.
// Build option MULT_SCHED_FIXED_PRIO_EN: requester 0 always wins contention (no round-robin).
module mult_issue_scheduler #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  input  logic        flush,
  output logic        mult_issue,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] mult_product,
  output logic        done0_valid,
  output logic        done1_valid,
  output logic [31:0] done_product,
  output logic        busy,
  output logic        flush_done
);

  localparam int unsigned CntW = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [LATENCY:0] tag_valid_q, tag_id_q;
  logic             accept, gnt1, retire, retire_id;
  logic             mult_issue_q, done0_q, done1_q;
  logic [31:0]      mult_a_q, mult_b_q, done_product_q;

`ifdef MULT_SCHED_FIXED_PRIO_EN
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && state_q != StDrain) begin
      req0_ready = req0_valid;
      req1_ready = req1_valid & ~req0_valid;
    end
  end
`else
  logic ptr_q;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && state_q != StDrain) begin
      if (req0_valid && req1_valid) begin
        req0_ready = ~ptr_q;
        req1_ready = ptr_q;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  // Pointer only moves when it actually resolved a contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (req0_valid && req1_valid && accept) begin
      ptr_q <= ~ptr_q;
    end
  end
`endif

  assign gnt1      = req1_valid & req1_ready;
  assign accept    = (req0_valid & req0_ready) | gnt1;
  assign retire    = tag_valid_q[LATENCY];
  assign retire_id = tag_id_q[LATENCY];

  always_comb begin
    count_d = count_q;
    if (accept && !retire) begin
      count_d = count_q + CntW'(1);
    end else if (!accept && retire) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Drain completes only once the final result strobe has also left the block.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (flush) begin
          state_d = StDrain;
        end else if (accept) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StDrain;
        end else if (count_d == '0) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (count_q == '0 && !done0_q && !done1_q) begin
          flush_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      count_q        <= '0;
      tag_valid_q    <= '0;
      tag_id_q       <= '0;
      mult_issue_q   <= 1'b0;
      mult_a_q       <= '0;
      mult_b_q       <= '0;
      done0_q        <= 1'b0;
      done1_q        <= 1'b0;
      done_product_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      tag_valid_q  <= {tag_valid_q[LATENCY-1:0], accept};
      tag_id_q     <= {tag_id_q[LATENCY-1:0], gnt1};
      mult_issue_q <= accept;
      if (accept) begin
        mult_a_q <= gnt1 ? req1_a : req0_a;
        mult_b_q <= gnt1 ? req1_b : req0_b;
      end
      done0_q <= retire & ~retire_id;
      done1_q <= retire & retire_id;
      if (retire) begin
        done_product_q <= mult_product;
      end
    end
  end

  assign mult_issue   = mult_issue_q;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;
  assign done0_valid  = done0_q;
  assign done1_valid  = done1_q;
  assign done_product = done_product_q;
  assign busy         = (count_q != '0) | done0_q | done1_q;

endmodule

// File: tb/tb_mult_issue_scheduler.sv
// Directed self-checking bench for mult_issue_scheduler with a behavioural LATENCY-stage multiplier.
module tb_mult_issue_scheduler;

  localparam int unsigned LAT = 4;

  logic        clock, reset, flush;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        mult_issue, done0_valid, done1_valid, busy, flush_done;
  logic [31:0] mult_a, mult_b, mult_product, done_product;

  mult_issue_scheduler #(.LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .flush(flush), .mult_issue(mult_issue), .mult_a(mult_a), .mult_b(mult_b),
    .mult_product(mult_product), .done0_valid(done0_valid), .done1_valid(done1_valid),
    .done_product(done_product), .busy(busy), .flush_done(flush_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Multiplier environment: operands sampled on the edge ending the issue cycle.
  logic [31:0] mpipe [LAT];
  always @(posedge clock) begin
    mpipe[0] <= (mult_issue === 1'b1) ? mult_a * mult_b : 32'hDEADBEEF;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_product = mpipe[LAT-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int both_hi = 0, fd_cnt = 0, fd_cyc = 0, iss_cnt = 0, acc_cnt = 0;
  int          got_id[$];
  logic [31:0] got_prod[$];
  int          got_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (done0_valid === 1'b1) begin
      got_id.push_back(0); got_prod.push_back(done_product); got_cyc.push_back(cyc);
    end
    if (done1_valid === 1'b1) begin
      got_id.push_back(1); got_prod.push_back(done_product); got_cyc.push_back(cyc);
    end
    if ((done0_valid & done1_valid) === 1'b1) both_hi <= both_hi + 1;
    if (flush_done === 1'b1) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
    if (mult_issue === 1'b1) iss_cnt <= iss_cnt + 1;
    if (((req0_valid & req0_ready) | (req1_valid & req1_ready)) === 1'b1) acc_cnt <= acc_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic collect(input int n, input int budget);
    for (int t = 0; t < budget && got_id.size() < n; t++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    checks++;
    if ({mult_issue, mult_a, mult_b, done0_valid, done1_valid, done_product, busy, flush_done}
        !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {mult_issue, mult_a, mult_b, done0_valid, done1_valid, done_product, busy, flush_done});
    end
    idle_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    tick();
    req0_valid = 1'b1; req0_a = 32'h3; req0_b = 32'h5;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("FAIL single_ready got=%b exp=1", req0_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if ({mult_issue, mult_a, mult_b, busy} !== {1'b1, 32'h3, 32'h5, 1'b1}) begin
      failures++;
      $display("FAIL single_issue got=%h exp=%h", {mult_issue, mult_a, mult_b, busy},
               {1'b1, 32'h3, 32'h5, 1'b1});
    end
    for (int i = 1; i <= LAT; i++) begin
      tick();
      checks++;
      if ({done0_valid, done1_valid, mult_issue, mult_a} !== {3'b000, 32'h3}) begin
        failures++;
        $display("FAIL single_wait%0d got=%h exp=%h", i, {done0_valid, done1_valid, mult_issue, mult_a},
                 {3'b000, 32'h3});
      end
    end
    tick();
    checks++;
    if ({done0_valid, done1_valid, done_product, busy} !== {2'b10, 32'h0000000F, 1'b1}) begin
      failures++;
      $display("FAIL single_done got=%h exp=%h", {done0_valid, done1_valid, done_product, busy},
               {2'b10, 32'h0000000F, 1'b1});
    end
    tick();
    checks++;
    if ({done0_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL single_after got=%b exp=00", {done0_valid, busy});
    end
  endtask

  task automatic test_contention();
    int          exp_id[6];
    logic [31:0] exp_p[6];
    int          e;
    got_id.delete(); got_prod.delete(); got_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      req0_valid = 1'b1; req0_a = 32'(10 + i); req0_b = 32'd2;
      req1_valid = 1'b1; req1_a = 32'(20 + i); req1_b = 32'd3;
      #1;
`ifdef MULT_SCHED_FIXED_PRIO_EN
      e = 0;
`else
      e = i % 2;
`endif
      exp_id[i] = e;
      exp_p[i]  = (e == 0) ? 32'((10 + i) * 2) : 32'((20 + i) * 3);
      checks++;
      if ({req0_ready, req1_ready} !== ((e == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL contention_grant%0d got=%b exp=%b", i, {req0_ready, req1_ready},
                 (e == 0) ? 2'b10 : 2'b01);
      end
    end
    tick();
    idle_inputs();
    collect(6, 20);
    checks++;
    if (got_id.size() !== 6) begin
      failures++; $display("FAIL contention_count got=%0d exp=6", got_id.size());
    end
    for (int j = 0; j < 6 && j < got_id.size(); j++) begin
      checks++;
      if (got_id[j] !== exp_id[j] || got_prod[j] !== exp_p[j]) begin
        failures++;
        $display("FAIL contention_result%0d got=id%0d/%h exp=id%0d/%h", j, got_id[j], got_prod[j],
                 exp_id[j], exp_p[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e_first;
    got_id.delete(); got_prod.delete(); got_cyc.delete();
    e_first = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) e_first = cyc;
      req1_valid = 1'b1; req1_a = 32'h11111111; req1_b = 32'(i);
      #1;
      checks++;
      if (req1_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, req1_ready);
      end
    end
    tick();
    idle_inputs();
    collect(8, 20);
    checks++;
    if (got_id.size() !== 8) begin
      failures++; $display("FAIL b2b_count got=%0d exp=8", got_id.size());
    end
    for (int j = 0; j < 8 && j < got_id.size(); j++) begin
      checks++;
      if (got_id[j] !== 1 || got_prod[j] !== 32'h11111111 * 32'(j) ||
          got_cyc[j] !== e_first + 2 + int'(LAT) + j) begin
        failures++;
        $display("FAIL b2b_result%0d got=id%0d/%h@%0d exp=id1/%h@%0d", j, got_id[j], got_prod[j],
                 got_cyc[j], 32'h11111111 * 32'(j), e_first + 2 + int'(LAT) + j);
      end
    end
  endtask

  task automatic test_flush();
    int acc0, fd0;
    got_id.delete(); got_prod.delete(); got_cyc.delete();
    fd0 = fd_cnt;
    for (int i = 0; i < 3; i++) begin
      tick();
      req0_valid = 1'b1; req0_a = 32'(i + 2); req0_b = 32'd7;
    end
    tick();
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    acc0 = acc_cnt;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL flush_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    collect(3, 20);
    idle_inputs();
    checks++;
    if (acc_cnt !== acc0) begin
      failures++; $display("FAIL flush_no_accept got=%0d exp=%0d", acc_cnt, acc0);
    end
    checks++;
    if (got_id.size() !== 3) begin
      failures++; $display("FAIL flush_count got=%0d exp=3", got_id.size());
    end
    for (int j = 0; j < 3 && j < got_id.size(); j++) begin
      checks++;
      if (got_id[j] !== 0 || got_prod[j] !== 32'((j + 2) * 7)) begin
        failures++;
        $display("FAIL flush_result%0d got=id%0d/%h exp=id0/%h", j, got_id[j], got_prod[j],
                 32'((j + 2) * 7));
      end
    end
    checks++;
    if (flush_done !== 1'b1) begin
      failures++; $display("FAIL flush_done_pulse got=%b exp=1", flush_done);
    end
    tick();
    checks++;
    if ({flush_done, busy} !== 2'b00 || fd_cnt - fd0 !== 1 ||
        (got_cyc.size() == 3 && fd_cyc !== got_cyc[2] + 1)) begin
      failures++;
      $display("FAIL flush_done_once got=%b/%0d pulses@%0d exp=00/1 pulse after last done",
               {flush_done, busy}, fd_cnt - fd0, fd_cyc);
    end
    req1_valid = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++; $display("FAIL flush_idle_again got=%b exp=1", req1_ready);
    end
    req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    got_id.delete(); got_prod.delete(); got_cyc.delete();
    tick();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd1;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL rstmid_first got=%b exp=10", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0; req0_b = 32'd2;
    tick();
    req0_b = 32'd3;
    tick();
    idle_inputs();
    tick(); tick();
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL rstmid_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    for (int t = 0; t < int'(LAT) + 4; t++) tick();
    checks++;
    if (got_id.size() !== 0 || {busy, mult_issue} !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_quiet got=%0d strobes busy/issue=%b exp=0 strobes 00", got_id.size(),
               {busy, mult_issue});
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++; $display("FAIL rstmid_ptr got=%b exp=10", {req0_ready, req1_ready});
    end
    idle_inputs();
    #1;
  endtask

  task automatic test_flush_idle();
    int iss0, fd0;
    iss0 = iss_cnt;
    fd0  = fd_cnt;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({flush_done, mult_issue} !== 2'b10) begin
      failures++; $display("FAIL flush_idle_pulse got=%b exp=10", {flush_done, mult_issue});
    end
    tick();
    checks++;
    if ({flush_done, busy} !== 2'b00 || fd_cnt - fd0 !== 1 || iss_cnt !== iss0) begin
      failures++;
      $display("FAIL flush_idle_after got=%b pulses=%0d issues=%0d exp=00 pulses=1 issues=0",
               {flush_done, busy}, fd_cnt - fd0, iss_cnt - iss0);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_flush_idle();
    checks++;
    if (both_hi !== 0) begin
      failures++; $display("FAIL done_exclusive got=%0d exp=0", both_hi);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
